// File: rtl/xcalc_seq.sv
// ---------------------------------------------------------------------------
// xcalc_seq : calculator entry sequencer
//
// Debounces the enter/clear push-buttons, collects operand A, the operation
// and operand B from the switches, fires the ALU with a one-cycle start
// pulse, waits for completion (with timeout) and drives the display decoder.
//
// Build option:
//   CALC_CHAIN_EN  when defined, enter in SHOW feeds the result back as
//                  operand A and resumes at GET_OP (chained calculation);
//                  when undefined, enter in SHOW restarts from GET_A.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_btn_ent      raw enter button, asynchronous
//   i_btn_clr      raw clear button, asynchronous
//   i_sw[7:0]      switches (operands, op = sw[1:0])
//   o_alu_a/b      operands to the ALU
//   o_alu_op       00 add, 01 sub, 10 mul, 11 div
//   o_alu_start    one-cycle ALU start pulse
//   i_alu_done     ALU completion strobe
//   i_alu_err      ALU error flag, valid with i_alu_done
//   i_alu_result   ALU result, valid with i_alu_done
//   o_disp_msg     00 normal, 01 OP, 10 VAL, 11 ERR
//   o_disp_bin     value to display
//   o_disp_we      one-cycle display write strobe
//   o_status       current state encoding
// ---------------------------------------------------------------------------

// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module xcalc_seq_db #(
    parameter int DB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the count,
            // so the level only flips after DB_CYCLES differing samples in a row.
            if (r_sync2 != r_level) begin
                if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;
endmodule

// state   | meaning
// --------+-----------------------------------------------
// GET_A   | waiting for enter to capture operand A
// GET_OP  | waiting for enter to capture the operation
// GET_B   | waiting for enter to capture operand B
// RUN     | one cycle, ALU start pulse asserted
// WAIT    | waiting for alu_done, timer running
// SHOW    | result on the display, waiting for enter
// ERR     | div-by-zero, ALU error or timeout shown
module xcalc_seq #(
    parameter int DB_CYCLES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_ent,
    input  logic       i_btn_clr,
    input  logic [7:0] i_sw,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic [1:0] o_alu_op,
    output logic       o_alu_start,
    input  logic       i_alu_done,
    input  logic       i_alu_err,
    input  logic [7:0] i_alu_result,
    output logic [1:0] o_disp_msg,
    output logic [7:0] o_disp_bin,
    output logic       o_disp_we,
    output logic [2:0] o_status
);
    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_OP = 3'd1,
        S_GET_B  = 3'd2,
        S_RUN    = 3'd3,
        S_WAIT   = 3'd4,
        S_SHOW   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] MSG_NORM = 2'b00;
    localparam logic [1:0] MSG_OP   = 2'b01;
    localparam logic [1:0] MSG_VAL  = 2'b10;
    localparam logic [1:0] MSG_ERR  = 2'b11;

    logic w_press_ent;
    logic w_press_clr;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_a,       w_a_nxt;
    logic [7:0] r_b,       w_b_nxt;
    logic [1:0] r_op,      w_op_nxt;
    logic [7:0] r_result,  w_result_nxt;
    logic [7:0] r_tmr,     w_tmr_nxt;
    logic [1:0] r_disp_msg, w_disp_msg;
    logic [7:0] r_disp_bin, w_disp_bin;
    logic       r_disp_we,  w_disp_we;

    xcalc_seq_db #(.DB_CYCLES(DB_CYCLES)) u_db_ent (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_ent),
        .o_press (w_press_ent)
    );

    xcalc_seq_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_clr),
        .o_press (w_press_clr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_GET_A;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_tmr      <= '0;
            r_disp_msg <= '0;
            r_disp_bin <= '0;
            r_disp_we  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_result   <= w_result_nxt;
            r_tmr      <= w_tmr_nxt;
            r_disp_msg <= w_disp_msg;
            r_disp_bin <= w_disp_bin;
            r_disp_we  <= w_disp_we;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_tmr_nxt    = r_tmr;

        if (w_press_clr) begin
            // Clear has priority over enter and alu_done arriving together.
            w_state_nxt = S_GET_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
        end else begin
            case (r_state)
                S_GET_A: begin
                    if (w_press_ent) begin
                        w_a_nxt     = i_sw;
                        w_state_nxt = S_GET_OP;
                    end
                end
                S_GET_OP: begin
                    if (w_press_ent) begin
                        w_op_nxt    = i_sw[1:0];
                        w_state_nxt = S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (w_press_ent) begin
                        w_b_nxt = i_sw;
                        // Divide by zero is caught here and never reaches the ALU.
                        if (r_op == 2'b11 && i_sw == 8'd0)
                            w_state_nxt = S_ERR;
                        else
                            w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    w_tmr_nxt   = 8'(TIMEOUT);
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (i_alu_done) begin
                        if (i_alu_err) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_result_nxt = i_alu_result;
                            w_state_nxt  = S_SHOW;
                        end
                    end else if (r_tmr <= 8'd1) begin
                        // Terminal count: the TIMEOUT-th cycle spent in WAIT.
                        w_state_nxt = S_ERR;
                    end else begin
                        w_tmr_nxt = r_tmr - 8'd1;
                    end
                end
                S_SHOW: begin
                    if (w_press_ent) begin
`ifdef CALC_CHAIN_EN
                        w_a_nxt     = r_result;
                        w_state_nxt = S_GET_OP;
`else
                        w_a_nxt     = '0;
                        w_b_nxt     = '0;
                        w_op_nxt    = '0;
                        w_state_nxt = S_GET_A;
`endif
                    end
                end
                S_ERR: begin
                    if (w_press_ent)
                        w_state_nxt = S_GET_A;
                end
                default: w_state_nxt = S_GET_A;
            endcase
        end
    end

    // Display update follows the destination state; RUN and WAIT are
    // transient and leave the previous message on screen.
    always_comb begin
        w_disp_msg = r_disp_msg;
        w_disp_bin = r_disp_bin;
        w_disp_we  = 1'b0;
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_GET_A: begin
                    w_disp_we  = 1'b1;
                    w_disp_msg = MSG_VAL;
                    w_disp_bin = 8'd0;
                end
                S_GET_OP: begin
                    w_disp_we  = 1'b1;
                    w_disp_msg = MSG_OP;
                    w_disp_bin = w_a_nxt;
                end
                S_GET_B: begin
                    w_disp_we  = 1'b1;
                    w_disp_msg = MSG_VAL;
                    w_disp_bin = w_a_nxt;
                end
                S_SHOW: begin
                    w_disp_we  = 1'b1;
                    w_disp_msg = MSG_NORM;
                    w_disp_bin = w_result_nxt;
                end
                S_ERR: begin
                    w_disp_we  = 1'b1;
                    w_disp_msg = MSG_ERR;
                    w_disp_bin = 8'd0;
                end
                default: begin
                    w_disp_we = 1'b0;
                end
            endcase
        end
    end

    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_alu_op    = r_op;
    assign o_alu_start = (r_state == S_RUN);
    assign o_disp_msg  = r_disp_msg;
    assign o_disp_bin  = r_disp_bin;
    assign o_disp_we   = r_disp_we;
    assign o_status    = r_state;
endmodule
